// File: rtl/sha3_pkg.sv
// rtl/sha3_pkg.sv - shared constants, FSM state type and pad-mask helper for sha3_pad
package sha3_pkg;

  localparam int         NLANES    = 25;
  localparam logic [7:0] DOM_SHA3  = 8'h06;
  localparam logic [7:0] DOM_SHAKE = 8'h1F;
  localparam logic [7:0] PAD_END   = 8'h80;

  typedef enum logic [1:0] {
    ABSORB,
    PAD,
    CAP
  } state_e;

  // Bits to OR into rate lane 'lane' when the domain byte sits at block byte 'pos'.
  function automatic logic [63:0] pad_mask(input logic [7:0] pos, input logic [4:0] lane,
                                           input int rate_lanes, input logic [7:0] dom);
    logic [63:0] m;
    m = '0;
    if (pos[7:3] == lane) m[{pos[2:0], 3'b000} +: 8] = dom;
    if (lane == 5'(rate_lanes - 1)) m[63:56] = m[63:56] | PAD_END;
    return m;
  endfunction

endpackage

// File: rtl/sha3_pad.sv
// rtl/sha3_pad.sv - byte-to-lane packer and pad10*1 padder feeding perm_blk as 25-lane bursts
// Build option: SHA3_PAD_SHAKE_EN selects the SHAKE domain byte instead of the SHA-3 one.
module sha3_pad
  import sha3_pkg::*;
#(
  parameter int RATE_LANES = 17
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pushin,
  output logic        stopin,
  input  logic        lastin,
  input  logic        emptyin,
  input  logic [7:0]  din,
  output logic        pushout,
  input  logic        stopout,
  output logic        firstout,
  output logic [63:0] dout
);

`ifdef SHA3_PAD_SHAKE_EN
  localparam logic [7:0] DOM = DOM_SHAKE;
`else
  localparam logic [7:0] DOM = DOM_SHA3;
`endif
  localparam logic [7:0] BC_LAST      = 8'(8 * RATE_LANES - 1);
  localparam logic [4:0] LI_LAST_RATE = 5'(RATE_LANES - 1);
  localparam logic [4:0] LI_LAST      = 5'(NLANES - 1);

  state_e      state_q, state_d;
  logic [7:0]  bc_q, bc_d;
  logic [63:0] acc_q, acc_d;
  logic [4:0]  li_q, li_d;
  logic        pend_q, pend_d;
  logic        pushout_q, pushout_d;
  logic        firstout_q, firstout_d;
  logic [63:0] dout_q, dout_d;
  logic        load, out_free, take;
  logic [63:0] lane_val;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ABSORB;
      bc_q       <= '0;
      acc_q      <= '0;
      li_q       <= '0;
      pend_q     <= 1'b0;
      pushout_q  <= 1'b0;
      firstout_q <= 1'b0;
      dout_q     <= '0;
    end else begin
      state_q    <= state_d;
      bc_q       <= bc_d;
      acc_q      <= acc_d;
      li_q       <= li_d;
      pend_q     <= pend_d;
      pushout_q  <= pushout_d;
      firstout_q <= firstout_d;
      dout_q     <= dout_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    bc_d       = bc_q;
    acc_d      = acc_q;
    li_d       = li_q;
    pend_d     = pend_q;
    pushout_d  = pushout_q;
    firstout_d = firstout_q;
    dout_d     = dout_q;
    load       = 1'b0;
    lane_val   = '0;
    out_free   = !pushout_q || !stopout;
    stopin     = reset || (state_q != ABSORB) || (pushout_q && stopout);
    take       = pushin && !stopin;

    case (state_q)
      ABSORB: begin
        if (take) begin
          if (lastin && emptyin) begin
            // bc already points at the first unused byte: the domain position
            state_d = PAD;
          end else begin
            acc_d[{bc_q[2:0], 3'b000} +: 8] = din;
            bc_d = bc_q + 8'd1;
            if (bc_q[2:0] == 3'd7) begin
              load     = 1'b1;
              lane_val = acc_d;
              acc_d    = '0;
            end
            if (bc_q == BC_LAST) begin
              // message ending exactly on the block boundary needs a whole pad block
              bc_d    = '0;
              state_d = CAP;
              pend_d  = lastin;
            end else if (lastin) begin
              state_d = PAD;
            end
          end
        end
      end
      PAD: begin
        if (out_free) begin
          load     = 1'b1;
          lane_val = acc_q | pad_mask(bc_q, li_q, RATE_LANES, DOM);
          acc_d    = '0;
          if (li_q == LI_LAST_RATE) begin
            bc_d    = '0;
            state_d = CAP;
          end
        end
      end
      CAP: begin
        if (out_free) begin
          load = 1'b1;
          if (li_q == LI_LAST) begin
            state_d = pend_q ? PAD : ABSORB;
            pend_d  = 1'b0;
            bc_d    = '0;
          end
        end
      end
      default: state_d = ABSORB;
    endcase

    if (load) begin
      pushout_d  = 1'b1;
      firstout_d = (li_q == '0);
      dout_d     = lane_val;
      li_d       = (li_q == LI_LAST) ? '0 : li_q + 5'd1;
    end else if (pushout_q && !stopout) begin
      pushout_d  = 1'b0;
      firstout_d = 1'b0;
    end
  end

  assign pushout  = pushout_q;
  assign firstout = firstout_q;
  assign dout     = dout_q;

endmodule

// File: tb/tb_sha3_pad.sv
// tb/tb_sha3_pad.sv - self-checking bench for sha3_pad against a byte-array padding model
module tb_sha3_pad;

  localparam int R  = 17;
  localparam int RB = 8 * R;
`ifdef SHA3_PAD_SHAKE_EN
  localparam logic [7:0] DOM = 8'h1F;
`else
  localparam logic [7:0] DOM = 8'h06;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        pushin = 1'b0, lastin = 1'b0, emptyin = 1'b0, stopout = 1'b0;
  logic [7:0]  din = '0;
  logic        stopin, pushout, firstout;
  logic [63:0] dout;

  always #5 clk = ~clk;

  sha3_pad #(.RATE_LANES(R)) dut (
    .clk(clk), .reset(reset), .pushin(pushin), .stopin(stopin), .lastin(lastin),
    .emptyin(emptyin), .din(din), .pushout(pushout), .stopout(stopout),
    .firstout(firstout), .dout(dout)
  );

  int chk_cnt = 0, pass_cnt = 0;
  bit rand_stall = 0;
  logic [63:0] got_lane[$], exp_lane[$];
  bit          got_first[$], exp_first[$];
  logic [7:0]  msg[$];

  always @(negedge clk)
    if (!reset && pushout && !stopout) begin
      got_lane.push_back(dout);
      got_first.push_back(firstout);
    end

  always @(posedge clk) begin
    #1;
    if (rand_stall) stopout = ($urandom_range(0, 3) == 0);
  end

  // Reference: pad the whole message as a byte array, then slice into 25-lane blocks.
  task automatic build_model();
    int nb = msg.size() / RB + 1;
    logic [7:0] b[];
    logic [63:0] lane;
    b = new[nb * RB];
    foreach (b[i]) b[i] = 8'h00;
    foreach (msg[i]) b[i] = msg[i];
    b[msg.size()] = b[msg.size()] | DOM;
    b[nb * RB - 1] = b[nb * RB - 1] | 8'h80;
    for (int blk = 0; blk < nb; blk++)
      for (int l = 0; l < 25; l++) begin
        lane = '0;
        if (l < R) for (int k = 0; k < 8; k++) lane[8 * k +: 8] = b[blk * RB + 8 * l + k];
        exp_lane.push_back(lane);
        exp_first.push_back(l == 0);
      end
  endtask

  task automatic send_msg(input bit with_last, input bit end_empty, input bit gaps, output bit to);
    int n = msg.size();
    int total;
    int w;
    bit ok, is_empty;
    if (n == 0) end_empty = 1;
    total = n + ((with_last && end_empty) ? 1 : 0);
    to = 0;
    for (int t = 0; t < total && !to; t++) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        pushin = 0;
        @(posedge clk); #1;
      end
      is_empty = (t == n);
      pushin   = 1;
      din      = is_empty ? 8'($urandom) : msg[t];
      emptyin  = is_empty ? 1'b1 : (gaps && $urandom_range(0, 7) == 0);
      lastin   = with_last && (t == total - 1);
      w = 0;
      do begin
        @(negedge clk);
        ok = !stopin;
        @(posedge clk); #1;
        w++;
      end while (!ok && w < 2000);
      if (!ok) to = 1;
    end
    pushin = 0; lastin = 0; emptyin = 0;
  endtask

  task automatic wait_lanes(input int n);
    int c = 0;
    while (got_lane.size() < n && c < 5000) begin
      @(posedge clk); #1;
      c++;
    end
    repeat (30) @(posedge clk);
    #1;
  endtask

  task automatic clear_all();
    got_lane.delete(); got_first.delete(); exp_lane.delete(); exp_first.delete(); msg.delete();
  endtask

  task automatic test_reset();
    reset = 1; pushin = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_cnt++; if (stopin !== 1'b1) $display("FAIL reset_stopin got %b exp 1", stopin); else pass_cnt++;
    chk_cnt++; if (pushout !== 1'b0) $display("FAIL reset_pushout got %b exp 0", pushout); else pass_cnt++;
    chk_cnt++; if (firstout !== 1'b0) $display("FAIL reset_firstout got %b exp 0", firstout); else pass_cnt++;
    chk_cnt++; if (dout !== 64'h0) $display("FAIL reset_dout got %h exp 0", dout); else pass_cnt++;
    @(posedge clk); #1;
    pushin = 0; reset = 0;
  endtask

  task automatic test_empty();
    bit to;
    clear_all();
    build_model();
    send_msg(1, 1, 0, to);
    wait_lanes(25);
    chk_cnt++; if (got_lane.size() !== 25) $display("FAIL empty_count got %0d exp 25", got_lane.size()); else pass_cnt++;
    for (int i = 0; i < 25; i++) begin
      chk_cnt++;
      if (i >= got_lane.size() || got_lane[i] !== exp_lane[i] || got_first[i] !== exp_first[i])
        $display("FAIL empty_lane%0d got %h exp %h", i, (i < got_lane.size()) ? got_lane[i] : 64'hx, exp_lane[i]);
      else pass_cnt++;
    end
    chk_cnt++;
    if (got_lane.size() < 17 || got_lane[0] !== {56'h0, DOM} || got_lane[16] !== 64'h8000_0000_0000_0000)
      $display("FAIL empty_const got %h/%h exp %h/8000000000000000", got_lane.size() > 0 ? got_lane[0] : 64'hx,
               got_lane.size() > 16 ? got_lane[16] : 64'hx, {56'h0, DOM});
    else pass_cnt++;
  endtask

  task automatic test_abc();
    bit to;
    clear_all();
    msg = '{8'h61, 8'h62, 8'h63};
    build_model();
    send_msg(1, 0, 0, to);
    wait_lanes(25);
    chk_cnt++; if (got_lane.size() !== 25) $display("FAIL abc_count got %0d exp 25", got_lane.size()); else pass_cnt++;
    for (int i = 0; i < 25; i++) begin
      chk_cnt++;
      if (i >= got_lane.size() || got_lane[i] !== exp_lane[i] || got_first[i] !== exp_first[i])
        $display("FAIL abc_lane%0d got %h exp %h", i, (i < got_lane.size()) ? got_lane[i] : 64'hx, exp_lane[i]);
      else pass_cnt++;
    end
    chk_cnt++;
    if (got_lane.size() < 1 || got_lane[0] !== {32'h0, DOM, 24'h636261})
      $display("FAIL abc_lane0_const got %h exp %h", got_lane.size() > 0 ? got_lane[0] : 64'hx, {32'h0, DOM, 24'h636261});
    else pass_cnt++;
  endtask

  task automatic test_boundary(input int len);
    bit to;
    int nl, nf;
    logic [63:0] l16;
    clear_all();
    for (int i = 0; i < len; i++) msg.push_back(8'hFF);
    build_model();
    send_msg(1, 0, 0, to);
    nl = exp_lane.size();
    wait_lanes(nl);
    chk_cnt++; if (got_lane.size() !== nl) $display("FAIL len%0d_count got %0d exp %0d", len, got_lane.size(), nl); else pass_cnt++;
    nf = 0;
    foreach (got_first[i]) nf += got_first[i];
    chk_cnt++; if (nf !== nl / 25) $display("FAIL len%0d_firsts got %0d exp %0d", len, nf, nl / 25); else pass_cnt++;
    for (int i = 0; i < nl; i++) begin
      chk_cnt++;
      if (i >= got_lane.size() || got_lane[i] !== exp_lane[i] || got_first[i] !== exp_first[i])
        $display("FAIL len%0d_lane%0d got %h exp %h", len, i, (i < got_lane.size()) ? got_lane[i] : 64'hx, exp_lane[i]);
      else pass_cnt++;
    end
    l16 = (len == RB - 1) ? {DOM | 8'h80, 56'hFF_FFFF_FFFF_FFFF} : 64'h8000_0000_0000_0000;
    chk_cnt++;
    if (got_lane.size() < nl || got_lane[nl - 9] !== l16)
      $display("FAIL len%0d_padlane got %h exp %h", len, got_lane.size() >= nl ? got_lane[nl - 9] : 64'hx, l16);
    else pass_cnt++;
  endtask

  task automatic test_stall();
    bit to;
    int c;
    bit bad_hold, bad_stopin;
    logic [63:0] d0;
    clear_all();
    for (int i = 0; i < 100; i++) msg.push_back(8'($urandom));
    build_model();
    bad_hold = 0; bad_stopin = 0;
    fork
      send_msg(1, 0, 0, to);
      begin
        c = 0;
        do begin
          @(posedge clk); #1;
          c++;
        end while (!(got_lane.size() >= 5 && pushout) && c < 2000);
        stopout = 1;
        d0 = dout;
        repeat (10) begin
          @(negedge clk);
          if (dout !== d0 || pushout !== 1'b1 || firstout !== 1'b0) bad_hold = 1;
          if (stopin !== 1'b1) bad_stopin = 1;
        end
        @(posedge clk); #1;
        stopout = 0;
      end
    join
    chk_cnt++; if (bad_hold || d0 !== exp_lane[5]) $display("FAIL stall_hold got %h exp %h", d0, exp_lane[5]); else pass_cnt++;
    chk_cnt++; if (bad_stopin) $display("FAIL stall_stopin got 0 exp 1"); else pass_cnt++;
    wait_lanes(25);
    chk_cnt++; if (got_lane.size() !== 25) $display("FAIL stall_count got %0d exp 25", got_lane.size()); else pass_cnt++;
    for (int i = 0; i < 25; i++) begin
      chk_cnt++;
      if (i >= got_lane.size() || got_lane[i] !== exp_lane[i] || got_first[i] !== exp_first[i])
        $display("FAIL stall_lane%0d got %h exp %h", i, (i < got_lane.size()) ? got_lane[i] : 64'hx, exp_lane[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_reset_mid();
    bit to;
    clear_all();
    for (int i = 0; i < 20; i++) msg.push_back(8'($urandom));
    send_msg(0, 0, 0, to);
    reset = 1;
    @(negedge clk);
    chk_cnt++; if (stopin !== 1'b1) $display("FAIL rstmid_stopin got %b exp 1", stopin); else pass_cnt++;
    @(posedge clk); #1;
    reset = 0;
    @(negedge clk);
    chk_cnt++; if (pushout !== 1'b0) $display("FAIL rstmid_pushout got %b exp 0", pushout); else pass_cnt++;
    clear_all();
    msg = '{8'h61, 8'h62, 8'h63};
    build_model();
    @(posedge clk); #1;
    send_msg(1, 0, 0, to);
    wait_lanes(25);
    chk_cnt++; if (got_lane.size() !== 25) $display("FAIL rstmid_count got %0d exp 25", got_lane.size()); else pass_cnt++;
    for (int i = 0; i < 25; i++) begin
      chk_cnt++;
      if (i >= got_lane.size() || got_lane[i] !== exp_lane[i] || got_first[i] !== exp_first[i])
        $display("FAIL rstmid_lane%0d got %h exp %h", i, (i < got_lane.size()) ? got_lane[i] : 64'hx, exp_lane[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_back_to_back();
    bit to;
    int len;
    for (int it = 0; it < 4; it++) begin
      clear_all();
      rand_stall = 1;
      for (int m = 0; m < 2; m++) begin
        msg.delete();
        len = (it == 0) ? (m == 0 ? 0 : 8) : $urandom_range(0, 300);
        for (int i = 0; i < len; i++) msg.push_back(8'($urandom));
        build_model();
        send_msg(1, $urandom_range(0, 1), 1, to);
      end
      wait_lanes(exp_lane.size());
      @(posedge clk); #1;
      rand_stall = 0;
      stopout = 0;
      wait_lanes(exp_lane.size());
      chk_cnt++;
      if (got_lane.size() !== exp_lane.size())
        $display("FAIL b2b%0d_count got %0d exp %0d", it, got_lane.size(), exp_lane.size());
      else pass_cnt++;
      for (int i = 0; i < exp_lane.size(); i++) begin
        chk_cnt++;
        if (i >= got_lane.size() || got_lane[i] !== exp_lane[i] || got_first[i] !== exp_first[i])
          $display("FAIL b2b%0d_lane%0d got %h exp %h", it, i, (i < got_lane.size()) ? got_lane[i] : 64'hx, exp_lane[i]);
        else pass_cnt++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_empty();
    test_abc();
    test_boundary(RB - 1);
    test_boundary(RB);
    test_stall();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
